windowed_sampler: RTL and testbench

Parametrised, multi-channel successor to the fixed 4-bit windowed sampler. A free-running frame counter defines a programmable sampling window. Inside the window, `data_in` is captured every `stride` counts. Outside the window, the output is either cleared or held. Sits between the input capture pins and downstream processing; window configuration is reprogrammable but only takes effect at frame boundaries.

---
 rtl/windowed_sampler.sv | 129 ++++++++++++
 tb/tb_windowed_sampler.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/windowed_sampler.sv
// Multi-channel windowed sampler: a free-running frame counter opens a programmable
// window in which data_in is captured every stride counts; config latches at frame wrap.
module windowed_sampler #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned NCH    = 1,
  parameter int unsigned CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [CNT_W-1:0]      start_cfg,
  input  logic [CNT_W-1:0]      end_cfg,
  input  logic [CNT_W-1:0]      stride_cfg,
  input  logic                  hold_mode,
  input  logic [NCH*DATA_W-1:0] data_in,
  output logic [NCH*DATA_W-1:0] data_out,
  output logic                  sample_valid,
  output logic                  window_active,
  output logic                  frame_done
);

  localparam int unsigned W = NCH * DATA_W;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] START_RST  = CNT_W'(4);
  localparam logic [CNT_W-1:0] END_RST    = CNT_W'(8);
  localparam logic [CNT_W-1:0] STRIDE_RST = CNT_W'(2);

  typedef enum logic [1:0] {
    ST_PRE,
    ST_WIN,
    ST_POST
  } state_e;

  state_e           state_q,         state_d;
  logic [CNT_W-1:0] cnt_q,           cnt_d;
  logic [CNT_W-1:0] start_q,         start_d;
  logic [CNT_W-1:0] end_q,           end_d;
  logic [CNT_W-1:0] stride_q,        stride_d;
  logic [CNT_W-1:0] phase_q,         phase_d;
  logic [W-1:0]     data_out_q,      data_out_d;
  logic             sample_valid_q,  sample_valid_d;
  logic             window_active_q, window_active_d;
  logic             frame_done_q,    frame_done_d;

  logic             wrap;
  logic             sample_due;

  always_comb begin
    wrap  = (cnt_q == CNT_MAX);
    cnt_d = cnt_q + CNT_ONE;

    start_d  = start_q;
    end_d    = end_q;
    stride_d = stride_q;
    if (wrap) begin
      start_d  = start_cfg;
      end_d    = end_cfg;
      stride_d = (stride_cfg == '0) ? CNT_ONE : stride_cfg;
    end

    // Wrap takes priority so a window reaching CNT_MAX still restarts cleanly.
    state_d = state_q;
    if (wrap) begin
      state_d = (start_d == '0) ? ST_WIN : ST_PRE;
    end else begin
      case (state_q)
        ST_PRE:  if (cnt_d == start_q) state_d = (start_q <= end_q) ? ST_WIN : ST_POST;
        ST_WIN:  if (cnt_q == end_q)   state_d = ST_POST;
        ST_POST: state_d = ST_POST;
        default: state_d = ST_PRE;
      endcase
    end

    // Phase restarts on every window entry, including WIN->WIN across a wrap.
    phase_d = '0;
    if (state_d == ST_WIN && (state_q != ST_WIN || wrap)) begin
      phase_d = '0;
    end else if (state_q == ST_WIN) begin
      phase_d = (phase_q == stride_q - CNT_ONE) ? '0 : phase_q + CNT_ONE;
    end

    sample_due     = (state_q == ST_WIN) && (phase_q == '0) && enable;
    sample_valid_d = sample_due;

    data_out_d = data_out_q;
    if (sample_due) begin
      data_out_d = data_in;
    end else if (enable && !hold_mode && state_q != ST_WIN) begin
      data_out_d = '0;
    end

    window_active_d = (state_d == ST_WIN);
    frame_done_d    = wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_PRE;
      cnt_q           <= '0;
      start_q         <= START_RST;
      end_q           <= END_RST;
      stride_q        <= STRIDE_RST;
      phase_q         <= '0;
      data_out_q      <= '0;
      sample_valid_q  <= 1'b0;
      window_active_q <= 1'b0;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      start_q         <= start_d;
      end_q           <= end_d;
      stride_q        <= stride_d;
      phase_q         <= phase_d;
      data_out_q      <= data_out_d;
      sample_valid_q  <= sample_valid_d;
      window_active_q <= window_active_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign data_out      = data_out_q;
  assign sample_valid  = sample_valid_q;
  assign window_active = window_active_q;
  assign frame_done    = frame_done_q;

endmodule

// File: tb/tb_windowed_sampler.sv
// Bench for windowed_sampler: a frame-level reference model feeds expectation queues
// that a negedge monitor drains and compares against the DUT outputs.
`timescale 1ns/1ps
module tb_windowed_sampler;

  localparam int DATA_W = 4;
  localparam int NCH    = 2;
  localparam int CNT_W  = 4;
  localparam int W      = DATA_W * NCH;
  localparam int FRAME  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             enable = 1'b0;
  logic             hold_mode = 1'b0;
  logic [CNT_W-1:0] start_cfg = CNT_W'(4);
  logic [CNT_W-1:0] end_cfg = CNT_W'(8);
  logic [CNT_W-1:0] stride_cfg = CNT_W'(2);
  logic [W-1:0]     data_in = '0;
  logic [W-1:0]     data_out;
  logic             sample_valid;
  logic             window_active;
  logic             frame_done;

  windowed_sampler #(.DATA_W(DATA_W), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .start_cfg(start_cfg), .end_cfg(end_cfg), .stride_cfg(stride_cfg),
    .hold_mode(hold_mode), .data_in(data_in), .data_out(data_out),
    .sample_valid(sample_valid), .window_active(window_active), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] dout;
    logic         sv;
    logic         wa;
    logic         fd;
  } exp_t;

  exp_t         exq[$];
  logic [W-1:0] smq[$];

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  // Model state: count of the current cycle and the config active in this frame.
  int           m_cnt, m_s, m_e, m_st;
  logic [W-1:0] m_dout;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t (model cnt %0d)", name, act, exp, $time, m_cnt);
    end
  endtask

  function automatic void model_reset();
    exp_t e;
    m_cnt  = 0;
    m_s    = 4;
    m_e    = 8;
    m_st   = 2;
    m_dout = '0;
    exq.delete();
    smq.delete();
    e = '0;
    exq.push_back(e);
  endfunction

  // Given the inputs present during cycle m_cnt, predict the outputs of the next cycle.
  function automatic void model_advance();
    exp_t e;
    bit in_win, due;
    in_win = (m_cnt >= m_s) && (m_cnt <= m_e);
    due    = in_win && (((m_cnt - m_s) % m_st) == 0) && enable;
    if (due) begin
      m_dout = data_in;
      smq.push_back(data_in);
    end else if (enable && !hold_mode && !in_win) begin
      m_dout = '0;
    end
    e.fd = (m_cnt == FRAME - 1);
    if (m_cnt == FRAME - 1) begin
      m_s  = int'(start_cfg);
      m_e  = int'(end_cfg);
      m_st = (stride_cfg == '0) ? 1 : int'(stride_cfg);
    end
    m_cnt  = (m_cnt + 1) % FRAME;
    e.dout = m_dout;
    e.sv   = due;
    e.wa   = (m_cnt >= m_s) && (m_cnt <= m_e);
    exq.push_back(e);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (exq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL status_queue: got empty queue expected an entry at t=%0t", $time);
      end else begin
        e = exq.pop_front();
        chk("data_out", data_out, e.dout);
        chk("sample_valid", sample_valid, e.sv);
        chk("window_active", window_active, e.wa);
        chk("frame_done", frame_done, e.fd);
        if (sample_valid) begin
          if (smq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sample: got unexpected sample %0h expected none at t=%0t", data_out, $time);
          end else begin
            chk("sample", data_out, smq.pop_front());
          end
        end
      end
    end
  end

  task automatic cyc(input bit en, input bit hm, input int s, input int e, input int st, input bit rnd);
    enable     = en;
    hold_mode  = hm;
    start_cfg  = CNT_W'(s);
    end_cfg    = CNT_W'(e);
    stride_cfg = CNT_W'(st);
    if (rnd) data_in = W'($urandom);
    else     data_in = {DATA_W'(m_cnt ^ 10), DATA_W'(m_cnt)};
    model_advance();
    @(posedge clk);
    #1;
  endtask

  // Asserted away from any clock edge; outputs must clear without waiting for clk.
  task automatic async_reset();
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("rst data_out", data_out, 0);
    chk("rst sample_valid", sample_valid, 0);
    chk("rst window_active", window_active, 0);
    chk("rst frame_done", frame_done, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    async_reset();
    for (int i = 0; i < 32; i++) cyc(1, 0, 4, 8, 2, 0);
    for (int i = 0; i < 32; i++) cyc(1, 1, 4, 8, 2, 0);
    for (int i = 0; i < 32; i++) begin
      if (i < 6) cyc(1, 0, 4, 8, 2, 0);
      else       cyc(1, 0, 2, 11, 3, 0);
    end
    for (int i = 0; i < 48; i++) cyc(1, 0, 9, 3, 1, 0);
    for (int i = 0; i < 32; i++) cyc(!(i >= 21 && i <= 23), 0, 4, 8, 2, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 4, 8, 2, 0);
    async_reset();
    for (int i = 0; i < 32; i++) cyc(1, 0, 4, 8, 0, 0);
    for (int i = 0; i < 640; i++) begin
      cyc($urandom_range(0, 7) != 0, 1'($urandom), int'($urandom_range(0, FRAME - 1)),
          int'($urandom_range(0, FRAME - 1)), int'($urandom_range(0, 5)), 1);
    end
    #6;
    mon_en = 1'b0;
    chk("leftover samples", smq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
